// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI receive path.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SHIFT      = 2'd1,
        WAIT_DESEL = 2'd2
    } spi_rx_state_t;

    // Synchronizer reset levels match the transmitter's idle outputs.
    localparam logic SYNC_RST_CLK  = 1'b1;
    localparam logic SYNC_RST_SEL  = 1'b1;
    localparam logic SYNC_RST_DATA = 1'b0;

endpackage

// File: rtl/spi_rx_sync_ff.sv
// Multi-flop synchronizer for one asynchronous serial input.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic d_in,
    output logic q_out
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d_in};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            chain_q <= {STAGES{RESET_VAL}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q_out = chain_q[STAGES-1];

endmodule

// File: rtl/spi_rx.sv
// SPI receiver: synchronizes serial inputs, deserializes MSB-first frames and
// presents completed words on a valid/ready port with overrun and frame-error pulses.
module spi_rx
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  data_in,
    input  logic                  data_clk_in,
    input  logic                  sel_in,
    input  logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  overrun_out,
    output logic                  frame_err_out
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic d_s;
    logic c_s;
    logic s_s;
    logic rise_s;
    logic complete_s;
    logic [DATA_WIDTH-1:0] word_s;

    spi_rx_state_t         state_q,   state_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,   shift_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;
    logic                  valid_q,   valid_d;
    logic                  overrun_q, overrun_d;
    logic                  ferr_q,    ferr_d;
    logic                  c_prev_q,  c_prev_d;

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(SYNC_RST_DATA)) u_sync_data (
        .clk_in(clk_in), .rst_in(rst_in), .d_in(data_in), .q_out(d_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(SYNC_RST_CLK)) u_sync_clk (
        .clk_in(clk_in), .rst_in(rst_in), .d_in(data_clk_in), .q_out(c_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(SYNC_RST_SEL)) u_sync_sel (
        .clk_in(clk_in), .rst_in(rst_in), .d_in(sel_in), .q_out(s_s)
    );

    // c_prev follows c_s in every state so a level already high at select is not a rise.
    assign rise_s = c_s & ~c_prev_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = valid_q;
        overrun_d  = 1'b0;
        ferr_d     = 1'b0;
        c_prev_d   = c_s;
        complete_s = 1'b0;
        word_s     = {shift_q[DATA_WIDTH-2:0], d_s};

        if (valid_q && ready_in) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            IDLE: begin
                if (!s_s) begin
                    state_d = SHIFT;
                    cnt_d   = {CNT_W{1'b0}};
                    shift_d = {DATA_WIDTH{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // Deselect takes priority over a coincident rise.
                if (s_s) begin
                    ferr_d  = 1'b1;
                    shift_d = {DATA_WIDTH{1'b0}};
                    state_d = IDLE;
                end else if (rise_s) begin
                    shift_d = word_s;
                    if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        complete_s = 1'b1;
                        cnt_d      = {CNT_W{1'b0}};
                        state_d    = WAIT_DESEL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            WAIT_DESEL: begin
                if (s_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DESEL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (complete_s) begin
            if (!valid_q || ready_in) begin
                data_d  = word_s;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else begin
            data_d = data_q;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            shift_q   <= {DATA_WIDTH{1'b0}};
            data_q    <= {DATA_WIDTH{1'b0}};
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
            c_prev_q  <= SYNC_RST_CLK;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
            c_prev_q  <= c_prev_d;
        end
    end

    assign data_out      = data_q;
    assign valid_out     = valid_q;
    assign overrun_out   = overrun_q;
    assign frame_err_out = ferr_q;

endmodule
